// File: rtl/alu_share_if.sv
// alu_share_if: request/response bus between requesters and the shared-ALU arbiter
interface alu_share_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*3-1:0] req_op;
  logic rsp_valid;
  logic rsp_ready;
  logic [31:0] rsp_data;
  logic rsp_zero;
  logic [ID_W-1:0] rsp_id;
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input req_ready, rsp_valid, rsp_data, rsp_zero, rsp_id
  );
  modport slave (
    input req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_id
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU among NUM_REQ requesters; ALU_SHARE_OPCNT_EN enables op_count
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic clk,
  input  logic reset,
  alu_share_if.slave bus,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0] alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic alu_zero,
  output logic [31:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] last_grant, win, idx;
  logic found, grant;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    grant = (state == IDLE) && found;
    state_n = grant ? EXEC : (state == EXEC) ? RESP : (state == RESP && bus.rsp_ready) ? IDLE : state;
    bus.req_ready = grant ? NUM_REQ'(1) << win : '0;
  end
  assign bus.rsp_valid = (state == RESP);
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      alu_a <= '0;
      alu_b <= '0;
      alu_ctrl <= '0;
      bus.rsp_id <= '0;
      bus.rsp_data <= '0;
      bus.rsp_zero <= 1'b0;
    end else begin
      if (grant) begin
        alu_a <= bus.req_a[32*win +: 32];
        alu_b <= bus.req_b[32*win +: 32];
        alu_ctrl <= bus.req_op[3*win +: 3];
        last_grant <= win;
        bus.rsp_id <= win;
      end
      if (state == EXEC) begin
        bus.rsp_data <= alu_result;
        bus.rsp_zero <= alu_zero;
      end
    end
  end
`ifdef ALU_SHARE_OPCNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (grant) cnt <= cnt + 32'd1;
  end
  assign op_count = cnt;
`else
  assign op_count = '0;
`endif
endmodule
